// File: rtl/stream_pkg.sv
// Shared types and widths for the Avalon-ST packet source and its beat formatter.
package stream_pkg;

  localparam int unsigned SYM_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  function automatic int unsigned empty_w(input int unsigned data_bytes);
    return unsigned'($clog2(data_bytes));
  endfunction

endpackage

// File: rtl/stream_packet_gen_if.sv
// Avalon-ST beat bundle; master drives the beat, slave returns ready (readyLatency 0).
interface stream_packet_gen_if #(
  parameter int unsigned DATA_BYTES = 8
) ();
  import stream_pkg::*;

  localparam int unsigned EMPTY_W = empty_w(DATA_BYTES);

  logic [DATA_BYTES*SYM_W-1:0] data;
  logic [EMPTY_W-1:0]          empty;
  logic                        valid;
  logic                        startofpacket;
  logic                        endofpacket;
  logic                        ready;

  modport master (
    output data,
    output empty,
    output valid,
    output startofpacket,
    output endofpacket,
    input  ready
  );

  modport slave (
    input  data,
    input  empty,
    input  valid,
    input  startofpacket,
    input  endofpacket,
    output ready
  );

endinterface

// File: rtl/pattern_beat_gen.sv
// Builds one beat of incrementing bytes, first symbol in the MSBs, unused lanes zeroed.
module pattern_beat_gen
  import stream_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  localparam int unsigned EMPTY_W = empty_w(DATA_BYTES),
  localparam int unsigned CNT_W = EMPTY_W + 1
) (
  input  logic [SYM_W-1:0]            start_byte,
  input  logic [CNT_W-1:0]            byte_count,
  output logic [DATA_BYTES*SYM_W-1:0] data,
  output logic [EMPTY_W-1:0]          empty
);

  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (i < 32'(byte_count)) begin
        data[(DATA_BYTES-1-i)*SYM_W +: SYM_W] = start_byte + SYM_W'(i);
      end
    end
  end

  // byte_count is 1..DATA_BYTES, so a full beat truncates to an empty of 0
  assign empty = EMPTY_W'(DATA_BYTES - 32'(byte_count));

endmodule

// File: rtl/stream_packet_gen.sv
// Avalon-ST packet source: emits a burst of incrementing-byte packets with optional gaps.
module stream_packet_gen
  import stream_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [15:0] cfg_len,
  input  logic [15:0] cfg_num_pkts,
  input  logic [7:0]  cfg_seed,
  input  logic [7:0]  cfg_gap,
  output logic        busy,
  output logic        done,
  output logic [31:0] pkt_sent_count,
  stream_packet_gen_if.master stream_out
);

  localparam int unsigned EMPTY_W = empty_w(DATA_BYTES);
  localparam int unsigned CNT_W = EMPTY_W + 1;
  localparam int unsigned DATA_W = DATA_BYTES * SYM_W;
  localparam logic [15:0] BEAT_BYTES = 16'(DATA_BYTES);

  state_e state_q, state_d;

  logic [15:0]        len_q, num_q, pkt_idx_q, rem_q;
  logic [7:0]         gap_q, gap_cnt_q;
  logic [SYM_W-1:0]   pkt_base_q, beat_byte_q;
  logic               valid_q, sop_q, eop_q, busy_q, done_q;
  logic [DATA_W-1:0]  data_q;
  logic [EMPTY_W-1:0] empty_q;
  logic [31:0]        count_q;

  logic               start_ok, xfer, last_pkt;
  logic               load_beat, new_pkt, clear_out, done_d, count_inc;
  logic [SYM_W-1:0]   src_byte;
  logic [15:0]        src_rem;
  logic               src_eop;
  logic [CNT_W-1:0]   beat_count;
  logic [DATA_W-1:0]  beat_data;
  logic [EMPTY_W-1:0] beat_empty;

  assign start_ok = cfg_start && (cfg_len != 16'd0) && (cfg_num_pkts != 16'd0);
  assign xfer     = valid_q && stream_out.ready;
  assign last_pkt = (pkt_idx_q == num_q - 16'd1);

  // Comparing remaining bytes against the beat width avoids any 16-bit beat-count overflow
  assign src_eop    = (src_rem <= BEAT_BYTES);
  assign beat_count = src_eop ? src_rem[CNT_W-1:0] : CNT_W'(DATA_BYTES);

  pattern_beat_gen #(
    .DATA_BYTES(DATA_BYTES)
  ) u_beat_gen (
    .start_byte(src_byte),
    .byte_count(beat_count),
    .data      (beat_data),
    .empty     (beat_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = SEND;
      SEND: begin
        if (xfer && eop_q) begin
          if (last_pkt)            state_d = IDLE;
          else if (gap_q == 8'd0)  state_d = SEND;
          else                     state_d = GAP;
        end
      end
      GAP:  if (gap_cnt_q == 8'd1) state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_beat = 1'b0;
    new_pkt   = 1'b0;
    clear_out = 1'b0;
    done_d    = 1'b0;
    count_inc = 1'b0;
    src_byte  = beat_byte_q + SYM_W'(DATA_BYTES);
    src_rem   = rem_q - BEAT_BYTES;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          load_beat = 1'b1;
          new_pkt   = 1'b1;
          src_byte  = cfg_seed;
          src_rem   = cfg_len;
        end else if (cfg_start) begin
          done_d = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!eop_q) begin
            load_beat = 1'b1;
          end else begin
            count_inc = 1'b1;
            if (last_pkt) begin
              clear_out = 1'b1;
              done_d    = 1'b1;
            end else if (gap_q == 8'd0) begin
              load_beat = 1'b1;
              new_pkt   = 1'b1;
              src_byte  = pkt_base_q + 8'd1;
              src_rem   = len_q;
            end else begin
              clear_out = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd1) begin
          load_beat = 1'b1;
          new_pkt   = 1'b1;
          src_byte  = pkt_base_q + 8'd1;
          src_rem   = len_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      pkt_idx_q   <= '0;
      pkt_base_q  <= '0;
      rem_q       <= '0;
      beat_byte_q <= '0;
      gap_cnt_q   <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      empty_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      done_q <= done_d;
      busy_q <= (state_d != IDLE);
      if (count_inc) count_q <= count_q + 32'd1;

      if (state_q == IDLE) begin
        if (start_ok) begin
          len_q      <= cfg_len;
          num_q      <= cfg_num_pkts;
          gap_q      <= cfg_gap;
          pkt_idx_q  <= '0;
          pkt_base_q <= cfg_seed;
        end
      end else if (new_pkt) begin
        pkt_idx_q  <= pkt_idx_q + 16'd1;
        pkt_base_q <= pkt_base_q + 8'd1;
      end

      if (state_q == SEND && state_d == GAP) begin
        gap_cnt_q <= gap_q;
      end else if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q - 8'd1;
      end

      if (load_beat) begin
        valid_q     <= 1'b1;
        data_q      <= beat_data;
        empty_q     <= beat_empty;
        sop_q       <= new_pkt;
        eop_q       <= src_eop;
        rem_q       <= src_rem;
        beat_byte_q <= src_byte;
      end else if (clear_out) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        empty_q <= '0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end
    end
  end

  assign stream_out.valid         = valid_q;
  assign stream_out.data          = data_q;
  assign stream_out.empty         = empty_q;
  assign stream_out.startofpacket = sop_q;
  assign stream_out.endofpacket   = eop_q;
  assign busy                     = busy_q;
  assign done                     = done_q;
  assign pkt_sent_count           = count_q;

endmodule
